// File: rtl/matmul_seq_pkg.sv
// rtl/matmul_seq_pkg.sv - shared widths, defaults and FSM state encoding for the matmul sequencer
package matmul_seq_pkg;

    localparam int DW_DEF     = 4;
    localparam int MAXDIM_DEF = 3;
    localparam int ADDR_W     = 4;
    localparam int DIM_W      = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_X = 3'd2,
        CLR    = 3'd3,
        MAC    = 3'd4,
        RESULT = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_e;

endpackage

// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - job, element-load, bank, MAC and result signals of the matmul sequencer
interface matmul_sequencer_if
    import matmul_seq_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic              start;
    logic [DIM_W-1:0]  row_w;
    logic [DIM_W-1:0]  col_w;
    logic [DIM_W-1:0]  row_x;
    logic [DIM_W-1:0]  col_x;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              we_w;
    logic              we_x;
    logic [ADDR_W-1:0] rd_addr_w;
    logic [ADDR_W-1:0] rd_addr_x;
    logic              mac_ld;
    logic              mac_clr;
    logic              res_valid;
    logic              res_ready;
    logic [DIM_W-1:0]  res_row;
    logic [DIM_W-1:0]  res_col;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, row_w, col_w, row_x, col_x, in_data, in_valid, res_ready,
        output in_ready, wr_addr, we_w, we_x, rd_addr_w, rd_addr_x,
               mac_ld, mac_clr, res_valid, res_row, res_col, busy, done, err
    );

    modport slave (
        output start, row_w, col_w, row_x, col_x, in_data, in_valid, res_ready,
        input  in_ready, wr_addr, we_w, we_x, rd_addr_w, rd_addr_x,
               mac_ld, mac_clr, res_valid, res_row, res_col, busy, done, err
    );

endinterface

// File: rtl/matmul_addr_gen.sv
// rtl/matmul_addr_gen.sv - row-major W/X bank read addresses for output element (i,j), inner step k
module matmul_addr_gen
    import matmul_seq_pkg::*;
(
    input  logic [DIM_W-1:0]  i_i,
    input  logic [DIM_W-1:0]  j_i,
    input  logic [DIM_W-1:0]  k_i,
    input  logic [DIM_W-1:0]  col_w_i,
    input  logic [DIM_W-1:0]  col_x_i,
    output logic [ADDR_W-1:0] rd_addr_w_o,
    output logic [ADDR_W-1:0] rd_addr_x_o
);

    // Legal dimensions keep every index at or below 8, so 4-bit arithmetic never wraps.
    assign rd_addr_w_o = ADDR_W'(i_i) * ADDR_W'(col_w_i) + ADDR_W'(k_i);
    assign rd_addr_x_o = ADDR_W'(k_i) * ADDR_W'(col_x_i) + ADDR_W'(j_i);

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - load/clear/MAC/result sequencer for a small W*X matrix multiply
// Optional MATMUL_DIM_CHECK_EN: reject zero or mismatched dimensions into a sticky ERR state.
module matmul_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int MAXDIM = MAXDIM_DEF
)(
    input  logic clk,
    input  logic rst,
    matmul_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LOAD_W = LOAD_W;
    localparam logic [2:0] S_LOAD_X = LOAD_X;
    localparam logic [2:0] S_CLR    = CLR;
    localparam logic [2:0] S_MAC    = MAC;
    localparam logic [2:0] S_RESULT = RESULT;
    localparam logic [2:0] S_DONE   = DONE;
    localparam logic [2:0] S_ERR    = ERR;

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAXDIM * MAXDIM - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
    localparam logic [DIM_W-1:0]  DIM_ONE = DIM_W'(1);

    logic [2:0]        state_q, state_d;
    logic [DIM_W-1:0]  row_w_q, row_w_d;
    logic [DIM_W-1:0]  col_w_q, col_w_d;
    logic [DIM_W-1:0]  row_x_q, row_x_d;
    logic [DIM_W-1:0]  col_x_q, col_x_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DIM_W-1:0]  i_q, i_d;
    logic [DIM_W-1:0]  j_q, j_d;
    logic [DIM_W-1:0]  k_q, k_d;

    logic              dim_bad;
    logic              beat;
    logic [ADDR_W-1:0] w_last;
    logic [ADDR_W-1:0] x_last;
    logic [ADDR_W-1:0] gen_addr_w;
    logic [ADDR_W-1:0] gen_addr_x;
    logic [DW-1:0]     unused_in_data;

    // Element data flows straight from the source to the banks; only the handshake is sequenced here.
    assign unused_in_data = bus.in_data;

`ifdef MATMUL_DIM_CHECK_EN
    assign dim_bad = (bus.row_w == '0) || (bus.col_w == '0) || (bus.row_x == '0) ||
                     (bus.col_x == '0) || (bus.col_w != bus.row_x);
`else
    assign dim_bad = 1'b0;
`endif

    assign w_last = ADDR_W'(row_w_q) * ADDR_W'(col_w_q) - IDX_ONE;
    assign x_last = ADDR_W'(row_x_q) * ADDR_W'(col_x_q) - IDX_ONE;
    assign beat   = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        row_w_d = row_w_q;
        col_w_d = col_w_q;
        row_x_d = row_x_q;
        col_x_d = col_x_q;
        idx_d   = idx_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    row_w_d = bus.row_w;
                    col_w_d = bus.col_w;
                    row_x_d = bus.row_x;
                    col_x_d = bus.col_x;
                    idx_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = dim_bad ? S_ERR : S_LOAD_W;
                end
            end
            S_LOAD_W, S_LOAD_X: begin
                if (beat) begin
                    if (idx_q == ((state_q == S_LOAD_W) ? w_last : x_last)) begin
                        idx_d   = '0;
                        state_d = (state_q == S_LOAD_W) ? S_LOAD_X : S_CLR;
                    end else if (idx_q != MAX_IDX) begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            S_CLR: begin
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == col_w_q - DIM_ONE) begin
                    state_d = S_RESULT;
                end else begin
                    k_d = k_q + DIM_ONE;
                end
            end
            S_RESULT: begin
                // j is the inner loop, i the outer one.
                if (bus.res_ready) begin
                    if (j_q == col_x_q - DIM_ONE) begin
                        j_d = '0;
                        if (i_q == row_w_q - DIM_ONE) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d     = i_q + DIM_ONE;
                            state_d = S_CLR;
                        end
                    end else begin
                        j_d     = j_q + DIM_ONE;
                        state_d = S_CLR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_w_q <= '0;
            col_w_q <= '0;
            row_x_q <= '0;
            col_x_q <= '0;
            idx_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            row_w_q <= row_w_d;
            col_w_q <= col_w_d;
            row_x_q <= row_x_d;
            col_x_q <= col_x_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    matmul_addr_gen u_addr_gen (
        .i_i         (i_q),
        .j_i         (j_q),
        .k_i         (k_q),
        .col_w_i     (col_w_q),
        .col_x_i     (col_x_q),
        .rd_addr_w_o (gen_addr_w),
        .rd_addr_x_o (gen_addr_x)
    );

    assign bus.in_ready  = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
    assign bus.we_w      = (state_q == S_LOAD_W) && bus.in_valid;
    assign bus.we_x      = (state_q == S_LOAD_X) && bus.in_valid;
    assign bus.wr_addr   = (bus.we_w || bus.we_x) ? idx_q : '0;
    assign bus.mac_clr   = (state_q == S_CLR);
    assign bus.mac_ld    = (state_q == S_MAC);
    assign bus.rd_addr_w = bus.mac_ld ? gen_addr_w : '0;
    assign bus.rd_addr_x = bus.mac_ld ? gen_addr_x : '0;
    assign bus.res_valid = (state_q == S_RESULT);
    assign bus.res_row   = bus.res_valid ? i_q : '0;
    assign bus.res_col   = bus.res_valid ? j_q : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);

`ifdef MATMUL_DIM_CHECK_EN
    assign bus.err = (state_q == S_ERR);
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cyc;
    int   clr_cyc;
    logic seen_done;

    matmul_sequencer_if #(.DW(4)) bus ();

    matmul_sequencer #(.DW(4), .MAXDIM(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_job(input logic [1:0] rw, input logic [1:0] cw,
                           input logic [1:0] rx, input logic [1:0] cx);
        bus.row_w = rw;
        bus.col_w = cw;
        bus.row_x = rx;
        bus.col_x = cx;
    endtask

    int exp_aw [4][2] = '{'{0, 1}, '{0, 1}, '{2, 3}, '{2, 3}};
    int exp_ax [4][2] = '{'{0, 2}, '{1, 3}, '{0, 2}, '{1, 3}};

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        clr_cyc     = 0;
        rst         = 1'b1;
        bus.start     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        set_job(2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        tick();

        // Reset state
        bus.in_valid = 1'b1;
        settle();
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_we_w", bus.we_w, 0);
        chk("rst_mac_ld", bus.mac_ld, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Reset wins over start in the same cycle
        rst = 1'b1;
        bus.start = 1'b1;
        set_job(2'd1, 2'd1, 2'd1, 2'd1);
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        settle();
        chk("rst_prio_busy", bus.busy, 0);
        chk("rst_prio_in_ready", bus.in_ready, 0);
        tick();

        // 2x2 * 2x2 with res_ready high
        bus.start = 1'b1;
        set_job(2'd2, 2'd2, 2'd2, 2'd2);
        tick();
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(b + 1);
            settle();
            chk("m2_in_ready", bus.in_ready, 1);
            chk("m2_we_w", bus.we_w, (b < 4) ? 1 : 0);
            chk("m2_we_x", bus.we_x, (b < 4) ? 0 : 1);
            chk("m2_wr_addr", bus.wr_addr, b % 4);
            tick();
        end
        bus.in_valid = 1'b0;
        clr_cyc = cyc;
        for (int r = 0; r < 4; r++) begin
            settle();
            chk("m2_mac_clr", bus.mac_clr, 1);
            chk("m2_clr_mac_ld", bus.mac_ld, 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                settle();
                chk("m2_mac_ld", bus.mac_ld, 1);
                chk("m2_mac_clr_off", bus.mac_clr, 0);
                chk("m2_rd_addr_w", bus.rd_addr_w, exp_aw[r][k]);
                chk("m2_rd_addr_x", bus.rd_addr_x, exp_ax[r][k]);
                tick();
            end
            settle();
            chk("m2_res_valid", bus.res_valid, 1);
            chk("m2_res_row", bus.res_row, r / 2);
            chk("m2_res_col", bus.res_col, r % 2);
            tick();
        end
        settle();
        chk("m2_done", bus.done, 1);
        chk("m2_done_latency", cyc - clr_cyc, 16);
        chk("m2_done_busy", bus.busy, 1);
        tick();
        settle();
        chk("m2_idle_done", bus.done, 0);
        chk("m2_idle_busy", bus.busy, 0);
        bus.res_ready = 1'b0;
        tick();

        // 3x3 * 3x3 with in_valid toggling, then reset mid-MAC
        bus.start = 1'b1;
        set_job(2'd3, 2'd3, 2'd3, 2'd3);
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 18; n++) begin
            bus.in_valid = 1'b0;
            settle();
            chk("m3_gap_in_ready", bus.in_ready, 1);
            chk("m3_gap_we", {bus.we_w, bus.we_x}, 0);
            tick();
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(n);
            settle();
            chk("m3_we_w", bus.we_w, (n < 9) ? 1 : 0);
            chk("m3_we_x", bus.we_x, (n < 9) ? 0 : 1);
            chk("m3_wr_addr", bus.wr_addr, n % 9);
            tick();
        end
        bus.in_valid = 1'b0;
        settle();
        chk("m3_mac_clr", bus.mac_clr, 1);
        tick();
        settle();
        chk("m3_k0_addr_w", bus.rd_addr_w, 0);
        chk("m3_k0_addr_x", bus.rd_addr_x, 0);
        tick();
        rst = 1'b1;
        settle();
        chk("m3_k1_mac_ld", bus.mac_ld, 1);
        chk("m3_k1_addr_w", bus.rd_addr_w, 1);
        chk("m3_k1_addr_x", bus.rd_addr_x, 3);
        tick();
        rst = 1'b0;
        settle();
        chk("m3_abort_busy", bus.busy, 0);
        chk("m3_abort_mac_ld", bus.mac_ld, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            settle();
            seen_done = seen_done | bus.done;
        end
        chk("m3_no_done", seen_done, 0);
        tick();

        // 1x3 * 3x1 with late res_ready; a stray start mid-load is ignored
        bus.start = 1'b1;
        set_job(2'd1, 2'd3, 2'd3, 2'd1);
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            bus.in_valid = 1'b1;
            if (b == 1) begin
                bus.start = 1'b1;
                set_job(2'd2, 2'd2, 2'd2, 2'd2);
            end else begin
                bus.start = 1'b0;
            end
            settle();
            chk("m1_we_w", bus.we_w, (b < 3) ? 1 : 0);
            chk("m1_we_x", bus.we_x, (b < 3) ? 0 : 1);
            chk("m1_wr_addr", bus.wr_addr, b % 3);
            tick();
        end
        bus.in_valid = 1'b0;
        settle();
        chk("m1_mac_clr", bus.mac_clr, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("m1_mac_ld", bus.mac_ld, 1);
            chk("m1_rd_addr_w", bus.rd_addr_w, k);
            chk("m1_rd_addr_x", bus.rd_addr_x, k);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("m1_hold_valid", bus.res_valid, 1);
            chk("m1_hold_row", bus.res_row, 0);
            chk("m1_hold_col", bus.res_col, 0);
            chk("m1_hold_done", bus.done, 0);
            tick();
        end
        bus.res_ready = 1'b1;
        settle();
        chk("m1_hs_valid", bus.res_valid, 1);
        tick();
        bus.res_ready = 1'b0;
        settle();
        chk("m1_done", bus.done, 1);
        chk("m1_done_res_valid", bus.res_valid, 0);
        tick();
        settle();
        chk("m1_idle_busy", bus.busy, 0);
        tick();

        // Mismatched inner dimension: col_w=2, row_x=3
        bus.start = 1'b1;
        set_job(2'd2, 2'd2, 2'd3, 2'd2);
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        settle();
`ifdef MATMUL_DIM_CHECK_EN
        chk("chk_err", bus.err, 1);
        chk("chk_busy", bus.busy, 1);
        chk("chk_in_ready", bus.in_ready, 0);
        chk("chk_we_w", bus.we_w, 0);
        tick();
        settle();
        chk("chk_err_sticky", bus.err, 1);
        chk("chk_mac_ld", bus.mac_ld, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("chk_err_cleared", bus.err, 0);
        chk("chk_busy_cleared", bus.busy, 0);
`else
        chk("nochk_err", bus.err, 0);
        chk("nochk_in_ready", bus.in_ready, 1);
        chk("nochk_we_w", bus.we_w, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("nochk_busy_cleared", bus.busy, 0);
`endif
        bus.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter DW, default 4, SHALL set the matrix element width in bits.
REQ-002 Parameter MAXDIM, default 3, SHALL set the maximum rows/cols per matrix.
REQ-003 clk  in  1  SHALL be the single clock; every flop updates on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  in  1 SHALL request one multiply; row_w/col_w/row_x/col_x (in, 2 each) SHALL give the dimensions, sampled with start.
REQ-006 in_data  in  DW, in_valid  in  1, in_ready  out  1 SHALL form the element-load handshake.
REQ-007 wr_addr  out  4, we_w  out  1, we_x  out  1 SHALL form the W/X bank write port.
REQ-008 rd_addr_w  out  4, rd_addr_x  out  4 SHALL form the bank read addresses.
REQ-009 mac_ld  out  1, mac_clr  out  1 SHALL control the MAC accumulator.
REQ-010 res_valid  out  1, res_ready  in  1, res_row  out  2, res_col  out  2 SHALL tag each result; busy, done, err  out  1 SHALL give status.

Function
REQ-011 FSM states SHALL be IDLE, LOAD_W, LOAD_X, CLR, MAC, RESULT, DONE, ERR.
REQ-012 In IDLE, start=1 SHALL latch the dimensions and go to LOAD_W next cycle; start in any other state SHALL be ignored.
REQ-013 In LOAD_W/LOAD_X: in_ready=1; each in_valid&in_ready beat SHALL assert we_w/we_x with wr_addr = beat index (row-major), same cycle as the beat.
REQ-014 After beat row_w*col_w-1, FSM SHALL go to LOAD_X (index reset to 0); after beat row_x*col_x-1, to CLR.
REQ-015 in_valid outside LOAD_W/LOAD_X SHALL be ignored, with in_ready=0.
REQ-016 CLR SHALL assert mac_clr for exactly 1 cycle, then go to MAC.
REQ-017 MAC SHALL run col_w cycles, k=0..col_w-1, with mac_ld=1, rd_addr_w=i*col_w+k, rd_addr_x=k*col_x+j; then go to RESULT.
REQ-018 RESULT SHALL hold res_valid=1, res_row=i, res_col=j until res_ready=1.
REQ-019 On that handshake the FSM SHALL advance j (inner), then i (outer), and go to CLR; after i=row_w-1, j=col_x-1 it SHALL go to DONE.
REQ-020 DONE SHALL pulse done for 1 cycle, then go to IDLE.
REQ-021 With res_ready tied high, compute SHALL take row_w*col_x*(col_w+2) cycles.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 All address arithmetic SHALL be unsigned 4-bit; the maximum index is 8, so wrap-around SHALL NOT occur for legal dimensions.
REQ-024 Outside their active states, mac_ld, mac_clr, we_w, we_x and res_valid SHALL be 0, and the addresses SHALL be 0.

Reset
REQ-025 rst=1 SHALL force IDLE with all counters and outputs 0, including in_ready, busy, done and err.
REQ-026 rst mid-operation SHALL abandon the job without a done pulse; rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 With MATMUL_DIM_CHECK_EN defined, start with any dimension 0 or col_w!=row_x SHALL enter ERR.
REQ-028 ERR SHALL hold err=1 and busy=1 until rst; no loads, writes or MAC activity SHALL occur.
REQ-029 Without MATMUL_DIM_CHECK_EN, no check SHALL be made, err SHALL be tied 0, ERR SHALL be unreachable, and col_w SHALL be used as the inner dimension.

Structure
REQ-030 Package matmul_seq_pkg SHALL hold the state enum, DW/MAXDIM defaults and ADDR_W=4.
REQ-031 Sub-module matmul_addr_gen SHALL compute rd_addr_w and rd_addr_x from i, j, k, col_w and col_x combinationally.

Verification
REQ-032 2x2*2x2, W=1,2,3,4, X=5,6,7,8, res_ready=1 -> four results, (0,0),(0,1),(1,0),(1,1); each has rd_addr pairs (0,0)(1,2), (0,1)(1,3), (2,0)(3,2), (2,1)(3,3); done 16 cycles after the first CLR.
REQ-033 3x3*3x3, in_valid toggling every other cycle -> 18 writes at wr_addr 0..8 twice; no write on in_valid=0 cycles.
REQ-034 1x3*3x1, res_ready held 0 for 5 cycles -> res_valid, res_row=0, res_col=0 stable for 5 cycles; done 1 cycle after res_ready rises.
REQ-035 MATMUL_DIM_CHECK_EN, start with col_w=2, row_x=3 -> err=1 next cycle, in_ready=0, no we_w; rst clears err.
REQ-036 rst asserted during MAC of a 3x3 job -> next cycle busy=0, mac_ld=0, done never pulses; a new start runs normally.
